// File: rtl/camera_pkg.sv
// camera_pkg: state/pattern types, bar colours and jb bit positions shared by camera source and capture.
package camera_pkg;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT} tx_state_t;
    typedef enum logic [1:0] {PAT_BARS, PAT_GRAD, PAT_SOLID, PAT_CHECK} pattern_t;

    localparam int JB_PCLK  = 0;
    localparam int JB_VSYNC = 1;
    localparam int JB_HREF  = 2;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    localparam logic [15:0] BAR_RGB [8] = '{RGB_WHITE, RGB_YELLOW, RGB_CYAN, RGB_GREEN,
                                            RGB_MAGENTA, RGB_RED, RGB_BLUE, RGB_BLACK};

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// camera_pattern_gen: maps pixel coordinate, pattern mode and solid colour to an RGB565 value.
module camera_pattern_gen
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = 320
) (
    input  logic [15:0] x,
    input  logic [4:0]  y,
    input  pattern_t    mode,
    input  logic [15:0] solid,
    output logic [15:0] rgb
);

    logic [2:0] bar;

    always_comb begin
        bar = 3'((32'(x) * 8) / H_ACTIVE);
        rgb = mode == PAT_BARS  ? BAR_RGB[bar] :
              mode == PAT_GRAD  ? {x[4:0], x[5:0], y} :
              mode == PAT_SOLID ? solid :
              ((x[3] ^ y[3]) ? 16'hFFFF : 16'h0000);
    end

endmodule

// File: rtl/camera_pattern_tx.sv
// camera_pattern_tx: OV7670-style test-frame source driving pixel byte bus plus pclk/vsync/href.
module camera_pattern_tx
    import camera_pkg::*;
#(
    parameter int PCLK_HALF = 4,
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int H_BLANK   = 144,
    parameter int VS_LINES  = 3,
    parameter int VBP_LINES = 17,
    parameter int VFP_LINES = 10
) (
    input  logic        clk_100mhz,
    input  logic        reset_in_n,
    input  logic        enable_in,
    input  logic [1:0]  pattern_sel_in,
    input  logic [15:0] solid_rgb_in,
    output logic [7:0]  ja_out,
    output logic [2:0]  jb_out,
    output logic        busy_out,
    output logic        frame_done_out
);

    localparam int LINE    = 2 * H_ACTIVE + H_BLANK;
    localparam int VS_LEN  = VS_LINES * LINE;
    localparam int VBP_LEN = VBP_LINES * LINE;
    localparam int VFP_LEN = VFP_LINES * LINE;
    localparam int ACT_LEN = 2 * H_ACTIVE;
    localparam int CNT_MAX = max2(max2(VS_LEN, VBP_LEN), max2(max2(VFP_LEN, ACT_LEN), H_BLANK));
    localparam int CW      = max2(1, $clog2(CNT_MAX + 1));
    localparam int LW      = max2(1, $clog2(V_ACTIVE + 1));
    localparam int DW      = max2(1, $clog2(PCLK_HALF + 1));
    localparam tx_state_t AFTER_VS = VBP_LINES != 0 ? S_VBACK : S_ACTIVE;
    localparam tx_state_t FIRST    = VS_LINES != 0 ? S_VSYNC : AFTER_VS;

    logic [DW-1:0] div;
    logic          pclk, vsync, href, wrap, fall_tick, last, fin, start;
    tx_state_t     state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [LW-1:0] line, nxt_line;
    pattern_t      pat, nxt_pat;
    logic [15:0]   solid, nxt_solid, rgb;
    int            len;

    assign wrap      = div == DW'(PCLK_HALF - 1);
    assign fall_tick = wrap && pclk;

    // Phase lengths are in pclk cycles; zero-length phases are never entered.
    always_comb begin
        len = state == S_VSYNC  ? VS_LEN :
              state == S_VBACK  ? VBP_LEN :
              state == S_ACTIVE ? ACT_LEN :
              state == S_HBLANK ? H_BLANK : VFP_LEN;
        last      = int'(cnt) == len - 1;
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_line  = line;
        fin       = 1'b0;
        start     = 1'b0;
        if (fall_tick && state == S_IDLE) begin
            start     = enable_in;
            nxt_state = enable_in ? FIRST : S_IDLE;
        end else if (fall_tick && !last) begin
            nxt_cnt = cnt + 1'b1;
        end else if (fall_tick) begin
            nxt_cnt = '0;
            if (state == S_VSYNC) nxt_state = AFTER_VS;
            else if (state == S_VBACK) nxt_state = S_ACTIVE;
            else if (state == S_ACTIVE && H_BLANK != 0) nxt_state = S_HBLANK;
            else if (state != S_VFRONT && int'(line) != V_ACTIVE - 1) begin
                nxt_state = S_ACTIVE;
                nxt_line  = line + 1'b1;
            end else if (state != S_VFRONT && VFP_LINES != 0) nxt_state = S_VFRONT;
            else fin = 1'b1;
        end
        if (fin) begin
            start     = enable_in;
            nxt_state = enable_in ? FIRST : S_IDLE;
            nxt_line  = '0;
        end
        nxt_pat   = start ? pattern_t'(pattern_sel_in) : pat;
        nxt_solid = start ? solid_rgb_in : solid;
    end

    camera_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_gen (
        .x     (16'(nxt_cnt >> 1)),
        .y     (5'(nxt_line)),
        .mode  (nxt_pat),
        .solid (nxt_solid),
        .rgb   (rgb)
    );

    always_ff @(posedge clk_100mhz) begin
        if (!reset_in_n) begin
            div            <= '0;
            pclk           <= 1'b0;
            state          <= S_IDLE;
            cnt            <= '0;
            line           <= '0;
            pat            <= PAT_BARS;
            solid          <= '0;
            vsync          <= 1'b0;
            href           <= 1'b0;
            ja_out         <= '0;
            busy_out       <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            div            <= wrap ? '0 : div + 1'b1;
            pclk           <= wrap ? ~pclk : pclk;
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            line           <= nxt_line;
            pat            <= nxt_pat;
            solid          <= nxt_solid;
            vsync          <= nxt_state == S_VSYNC;
            href           <= nxt_state == S_ACTIVE;
            ja_out         <= nxt_state != S_ACTIVE ? 8'h00 : nxt_cnt[0] ? rgb[7:0] : rgb[15:8];
            busy_out       <= nxt_state != S_IDLE;
            frame_done_out <= fin;
        end
    end

    assign jb_out[JB_PCLK]  = pclk;
    assign jb_out[JB_VSYNC] = vsync;
    assign jb_out[JB_HREF]  = href;

endmodule

// File: tb/tb_camera_pattern_tx.sv
// tb_camera_pattern_tx: randomized frames scored per pclk rising edge against a frame-level reference model.
module tb_camera_pattern_tx;

    localparam int PH = 2, H = 8, V = 2, HB = 2, VS = 1, VBP = 1, VFP = 1;
    localparam int L = 2 * H + HB;
    localparam int FRAME_LEN = (VS + VBP + VFP + V) * L;

    logic        clk = 1'b0, rstn = 1'b0, en = 1'b0;
    logic [1:0]  sel = '0;
    logic [15:0] solid = '0;
    logic [7:0]  ja;
    logic [2:0]  jb;
    logic        busy, done;

    camera_pattern_tx #(
        .PCLK_HALF(PH), .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB),
        .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
    ) dut (
        .clk_100mhz     (clk),
        .reset_in_n     (rstn),
        .enable_in      (en),
        .pattern_sel_in (sel),
        .solid_rgb_in   (solid),
        .ja_out         (ja),
        .jb_out         (jb),
        .busy_out       (busy),
        .frame_done_out (done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    int          n_in_frame = 0, n_done = 0, n_rise = 0, clk_n = 0, last_rise = 0, rise_gap = 0;
    logic        expect_b2b = 1'b0;
    logic [9:0]  exp_q[$];
    logic [9:0]  prev_out = '0, cur, e;
    logic        prev_pclk = 1'b0, prev_done = 1'b0;
    logic [15:0] bar_rgb [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] model_rgb(input int x, input int y, input logic [1:0] p, input logic [15:0] s);
        case (p)
            2'd0:    return bar_rgb[x * 8 / H];
            2'd1:    return 16'((x % 32) * 2048 + (x % 64) * 32 + y % 32);
            2'd2:    return s;
            default: return ((x / 8) % 2 != (y / 8) % 2) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Expected {vsync, href, byte} seen at each pclk rise of one frame.
    task automatic push_frame(input logic [1:0] p, input logic [15:0] s);
        logic [15:0] c;
        repeat (VS * L) exp_q.push_back(10'h200);
        repeat (VBP * L) exp_q.push_back(10'h000);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                c = model_rgb(x, y, p, s);
                exp_q.push_back({2'b01, c[15:8]});
                exp_q.push_back({2'b01, c[7:0]});
            end
            repeat (HB) exp_q.push_back(10'h000);
        end
        repeat (VFP * L) exp_q.push_back(10'h000);
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (n_done == prev && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 32'(n_done != prev), 1);
    endtask

    task automatic wait_for(input string tag, input int which);
        int t = 0;
        while (!(which != 0 ? jb[2] : busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, which != 0 ? jb[2] : busy, 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            clk_n++;
            cur = {jb[1], jb[2], ja};
            if (rstn && cur != prev_out) check("edge_align", {prev_pclk, jb[0]}, 2'b10);
            if (rstn && !prev_pclk && jb[0]) begin
                n_rise++;
                rise_gap  = clk_n - last_rise;
                last_rise = clk_n;
                if (busy) begin
                    n_in_frame++;
                    e = exp_q.size() != 0 ? exp_q.pop_front() : 10'h3FF;
                    check("sample", cur, e);
                end
            end
            if (done) begin
                n_done++;
                check("done_width", prev_done, 0);
                check("frame_len", n_in_frame, FRAME_LEN);
                check("b2b_busy", busy, expect_b2b);
                check("b2b_vsync", jb[1], expect_b2b);
                n_in_frame = 0;
            end
            prev_out  = cur;
            prev_pclk = jb[0];
            prev_done = done;
        end
    end

    initial begin
        logic [1:0]  p;
        logic [15:0] s;
        int d, r0, bad;
        repeat (4) @(negedge clk);
        check("rst_ja", ja, 0);
        check("rst_jb", jb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rstn = 1'b1;
        r0 = n_rise;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            bad += int'(jb[1] | jb[2] | busy | (ja != 8'h00));
        end
        check("idle_quiet", bad, 0);
        check("idle_rises", n_rise - r0, 10);
        check("pclk_period", rise_gap, 4);

        sel = 2'd0;
        solid = 16'h0000;
        push_frame(2'd0, 16'h0000);
        expect_b2b = 1'b1;
        en = 1'b1;
        wait_for("start_timeout", 0);
        for (int f = 1; f <= 4; f++) begin
            p = f == 4 ? 2'd2 : 2'($urandom_range(0, 3));
            s = f == 4 ? 16'h1234 : 16'($urandom);
            sel = p;
            solid = s;
            push_frame(p, s);
            d = n_done;
            wait_done(d);
            repeat ($urandom_range(5, 60)) @(negedge clk);
            solid = 16'($urandom);
            sel = 2'($urandom);
        end
        wait_for("href_timeout", 1);
        repeat (3) @(negedge clk);
        en = 1'b0;
        expect_b2b = 1'b0;
        d = n_done;
        wait_done(d);
        repeat (20) @(negedge clk);
        check("idle_after", busy, 0);
        check("q_drained", exp_q.size(), 0);

        p = 2'($urandom);
        s = 16'($urandom);
        sel = p;
        solid = s;
        push_frame(p, s);
        en = 1'b1;
        wait_for("href2_timeout", 1);
        repeat (5) @(negedge clk);
        d = n_done;
        rstn = 1'b0;
        @(posedge clk);
        #2;
        check("mid_rst_ja", ja, 0);
        check("mid_rst_jb", jb, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (8) @(negedge clk);
        check("no_done_on_rst", n_done, d);
        exp_q.delete();
        n_in_frame = 0;

        p = 2'($urandom);
        s = 16'($urandom);
        sel = p;
        solid = s;
        push_frame(p, s);
        rstn = 1'b1;
        wait_for("restart_timeout", 0);
        en = 1'b0;
        d = n_done;
        wait_done(d);
        repeat (20) @(negedge clk);
        check("idle_final", busy, 0);
        check("q_drained2", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
